fetch_ibus_ctrl: RTL and testbench

- Fetch-side instruction bus controller between the fetch PC register and the decode stage.
- Takes f_pc from the fetch PC register and issues one instruction-bus request at a time.
- Returns F_stall to the PC register; queues {pc, instr} pairs in a small buffer for decode.
- Handles decode back-pressure, pipeline flush with in-flight response discard, and misaligned-PC exceptions.

---
 rtl/fetch_ibus_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fetch_ibus_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ibus_ctrl.sv
// rtl/fetch_ibus_ctrl.sv - fetch-side instruction bus controller feeding a small decode buffer
// Optional FETCH_BYPASS_EN: forward a returning word straight to decode when the buffer is empty.
module fetch_ibus_ctrl #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] f_pc,
  input  logic              f_valid,
  output logic              f_stall,
  input  logic              flush,
  output logic              ibus_req,
  output logic [ADDR_W-1:0] ibus_addr,
  input  logic              ibus_addr_ok,
  input  logic              ibus_data_ok,
  input  logic [31:0]       ibus_data,
  input  logic              d_stall,
  output logic              d_valid,
  output logic [ADDR_W-1:0] d_pc,
  output logic [31:0]       d_instr,
  output logic              d_adel
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              flushed_q, flushed_d;
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [DEPTH];
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       instr_mem_d [DEPTH];
  logic              adel_mem_q [DEPTH];
  logic              adel_mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push, pop, wr_en, bypass, has_room, f_aligned;
  logic [ADDR_W-1:0] push_pc;
  logic [31:0]       push_instr;
  logic              push_adel;

  assign has_room  = count_q < CNT_W'(DEPTH);
  assign f_aligned = f_pc[1:0] == 2'b00;
  assign ibus_req  = state_q == REQ;
  assign ibus_addr = addr_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    flushed_d  = flushed_q;
    f_stall    = 1'b1;
    push       = 1'b0;
    push_pc    = addr_q;
    push_instr = ibus_data;
    push_adel  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && f_valid && has_room) begin
          if (f_aligned) begin
            addr_d  = f_pc;
            state_d = REQ;
          end else begin
            push       = 1'b1;
            push_pc    = f_pc;
            push_instr = 32'h0;
            push_adel  = 1'b1;
            f_stall    = 1'b0;
          end
        end
      end
      REQ: begin
        // The request cannot be withdrawn; a flush only marks its response for discard.
        if (ibus_addr_ok) begin
          f_stall   = 1'b0;
          state_d   = (flush || flushed_q) ? DROP : WAIT;
          flushed_d = 1'b0;
        end else if (flush) begin
          flushed_d = 1'b1;
        end
      end
      WAIT: begin
        if (ibus_data_ok) begin
          push    = !flush;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (ibus_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FETCH_BYPASS_EN
  assign bypass = (state_q == WAIT) && ibus_data_ok && !flush && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode takes immediately never occupies a slot.
  assign wr_en   = push && !flush && !(bypass && !d_stall);
  assign pop     = (count_q != '0) && !d_stall;
  assign d_valid = (count_q != '0) || bypass;
  assign d_pc    = bypass ? addr_q    : pc_mem_q[rd_ptr_q];
  assign d_instr = bypass ? ibus_data : instr_mem_q[rd_ptr_q];
  assign d_adel  = bypass ? 1'b0      : adel_mem_q[rd_ptr_q];

  always_comb begin
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    adel_mem_d  = adel_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        pc_mem_d[wr_ptr_q]    = push_pc;
        instr_mem_d[wr_ptr_q] = push_instr;
        adel_mem_d[wr_ptr_q]  = push_adel;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_en && !pop) count_d = count_q + CNT_W'(1);
      else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      flushed_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
        adel_mem_q[i]  <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      flushed_q   <= flushed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
      adel_mem_q  <= adel_mem_d;
    end
  end
endmodule

// File: tb/tb_fetch_ibus_ctrl.sv
// tb/tb_fetch_ibus_ctrl.sv - self-checking bench for fetch_ibus_ctrl (vectors, directed corners, random vs model)
module tb_fetch_ibus_ctrl;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] f_pc;
  logic        f_valid;
  logic        f_stall;
  logic        flush;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_addr_ok;
  logic        ibus_data_ok;
  logic [31:0] ibus_data;
  logic        d_stall;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_adel;

  fetch_ibus_ctrl #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn), .f_pc(f_pc), .f_valid(f_valid), .f_stall(f_stall),
    .flush(flush), .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_addr_ok(ibus_addr_ok),
    .ibus_data_ok(ibus_data_ok), .ibus_data(ibus_data), .d_stall(d_stall), .d_valid(d_valid),
    .d_pc(d_pc), .d_instr(d_instr), .d_adel(d_adel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one outstanding bus transaction plus a queue of decoded entries.
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic adel; } ent_t;
  ent_t        mq[$];
  bit          m_req, m_resp, m_kill, m_fstall;
  logic [31:0] m_addr;

  task automatic model_reset();
    mq.delete();
    m_req  = 1'b0;
    m_resp = 1'b0;
    m_kill = 1'b0;
    m_addr = '0;
  endtask

  function automatic bit model_fstall();
    bit idle;
    idle = !m_req && !m_resp;
    if (!resetn) return 1'b1;
    if (m_req && ibus_addr_ok) return 1'b0;
    if (idle && !flush && f_valid && mq.size() < DEPTH && f_pc[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_model();
    m_fstall = model_fstall();
    if (!resetn) begin
      chk("rst_ibus_req", ibus_req, 0);
      chk("rst_ibus_addr", ibus_addr, 0);
      chk("rst_d_valid", d_valid, 0);
      chk("rst_d_pc", d_pc, 0);
      chk("rst_d_instr", d_instr, 0);
      chk("rst_d_adel", d_adel, 0);
      chk("rst_f_stall", f_stall, 1);
      return;
    end
    chk("ibus_req", ibus_req, m_req);
    if (m_req) chk("ibus_addr", ibus_addr, m_addr);
    chk("f_stall", f_stall, m_fstall);
    chk("d_valid", d_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("d_pc", d_pc, mq[0].pc);
      chk("d_instr", d_instr, mq[0].instr);
      chk("d_adel", d_adel, mq[0].adel);
    end
  endtask

  task automatic model_update();
    bit   idle, do_push, do_pop;
    ent_t e;
    if (!resetn) begin
      model_reset();
      return;
    end
    idle    = !m_req && !m_resp;
    do_push = 1'b0;
    do_pop  = mq.size() != 0 && !d_stall;
    e       = '{32'h0, 32'h0, 1'b0};
    if (idle) begin
      if (!flush && f_valid && mq.size() < DEPTH) begin
        if (f_pc[1:0] == 2'b00) begin
          m_req  = 1'b1;
          m_addr = f_pc;
          m_kill = 1'b0;
        end else begin
          e       = '{f_pc, 32'h0, 1'b1};
          do_push = 1'b1;
        end
      end
    end else if (m_req) begin
      if (flush) m_kill = 1'b1;
      if (ibus_addr_ok) begin
        m_req  = 1'b0;
        m_resp = 1'b1;
      end
    end else begin
      if (flush) m_kill = 1'b1;
      if (ibus_data_ok) begin
        m_resp = 1'b0;
        if (!m_kill) begin
          e       = '{m_addr, ibus_data, 1'b0};
          do_push = 1'b1;
        end
        m_kill = 1'b0;
      end
    end
    if (flush) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit fv, input logic [31:0] pc, input bit fl, input bit aok,
                       input bit dok, input logic [31:0] data, input bit dst);
    f_valid      = fv;
    f_pc         = pc;
    flush        = fl;
    ibus_addr_ok = aok;
    ibus_data_ok = dok;
    ibus_data    = data;
    d_stall      = dst;
  endtask

  typedef struct {
    bit fv; logic [31:0] pc; bit aok; bit dok; logic [31:0] data; bit dst;
    bit e_req; logic [31:0] e_addr; bit e_fstall; bit e_dv;
    logic [31:0] e_pc; logic [31:0] e_instr; bit e_adel;
  } vec_t;

  localparam int NV = 10;
  vec_t        vt[NV];
  logic [31:0] pc_reg;
  logic [31:0] pops[$];
  bit          fst;

  initial begin
    vt[0] = '{1, 32'hbfc0_0000, 0, 0, 32'h0,         1, 0, 32'h0,         1, 0, 32'h0,         32'h0,         0};
    vt[1] = '{1, 32'hbfc0_0004, 1, 0, 32'h0,         1, 1, 32'hbfc0_0000, 0, 0, 32'h0,         32'h0,         0};
    vt[2] = '{0, 32'hbfc0_0004, 0, 1, 32'h2408_0001, 1, 0, 32'h0,         1, 0, 32'h0,         32'h0,         0};
    vt[3] = '{0, 32'hbfc0_0004, 0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'hbfc0_0000, 32'h2408_0001, 0};
    vt[4] = '{0, 32'hbfc0_0004, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 32'hbfc0_0000, 32'h2408_0001, 0};
    vt[5] = '{0, 32'hbfc0_0004, 0, 0, 32'h0,         1, 0, 32'h0,         1, 0, 32'h0,         32'h0,         0};
    vt[6] = '{1, 32'hbfc0_0002, 0, 0, 32'h0,         1, 0, 32'h0,         0, 0, 32'h0,         32'h0,         0};
    vt[7] = '{0, 32'hbfc0_0002, 0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'hbfc0_0002, 32'h0,         1};
    vt[8] = '{0, 32'hbfc0_0002, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 32'hbfc0_0002, 32'h0,         1};
    vt[9] = '{0, 32'hbfc0_0002, 0, 0, 32'h0,         1, 0, 32'h0,         1, 0, 32'h0,         32'h0,         0};

    model_reset();
    resetn = 1'b0;
    drive(1, 32'hbfc0_0000, 0, 0, 0, 32'h0, 1);
    tick();
    tick();
    resetn = 1'b1;

    // Reset release, first aligned fetch, then a misaligned fetch.
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].fv, vt[i].pc, 0, vt[i].aok, vt[i].dok, vt[i].data, vt[i].dst);
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), ibus_req, vt[i].e_req);
      if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), ibus_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_fstall", i), f_stall, vt[i].e_fstall);
      chk($sformatf("vec%0d_dvalid", i), d_valid, vt[i].e_dv);
      if (vt[i].e_dv) begin
        chk($sformatf("vec%0d_dpc", i), d_pc, vt[i].e_pc);
        chk($sformatf("vec%0d_dinstr", i), d_instr, vt[i].e_instr);
        chk($sformatf("vec%0d_dadel", i), d_adel, vt[i].e_adel);
      end
      check_model();
      @(posedge clk);
      model_update();
      #1;
    end

    // Back-pressure: four-instruction stream with decode stalled, then released.
    pc_reg = 32'h100;
    pops.delete();
    for (int c = 0; c < 40; c++) begin
      drive(pc_reg < 32'h110, pc_reg, 0, 1, 1, m_addr ^ 32'h1111_0000, c < 20);
      @(negedge clk);
      check_model();
      if (c == 19) begin
        chk("bp_no_req_when_full", ibus_req, 0);
        chk("bp_head_held", d_pc, 32'h100);
      end
      if (d_valid && !d_stall) pops.push_back(d_pc);
      fst = m_fstall;
      @(posedge clk);
      model_update();
      if (!fst) pc_reg = pc_reg + 32'h4;
      #1;
    end
    chk("bp_pop_count", pops.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("bp_pop_order", (i < pops.size()) ? pops[i] : 32'hffff_ffff, 32'h100 + 32'(4 * i));

    // Flush in WAIT, late data goes through DROP and is discarded.
    drive(1, 32'h200, 0, 0, 0, 32'h0, 0); tick();
    drive(1, 32'h200, 0, 1, 0, 32'h0, 0); tick();
    drive(1, 32'h300, 1, 0, 0, 32'h0, 0); tick();
    drive(0, 32'h300, 0, 0, 0, 32'h0, 0); tick();
    chk("drop_no_req", ibus_req, 0);
    tick();
    drive(0, 32'h300, 0, 0, 1, 32'hdead_beef, 0); tick();
    chk("drop_no_push", d_valid, 0);
    chk("drop_no_beef", d_valid && d_instr == 32'hdead_beef, 0);
    drive(1, 32'h300, 0, 0, 0, 32'h0, 0); tick();
    chk("redirect_req", ibus_req, 1);
    chk("redirect_addr", ibus_addr, 32'h300);
    drive(0, 32'h300, 0, 1, 0, 32'h0, 1); tick();
    drive(0, 32'h300, 0, 0, 1, 32'h1111_2222, 1); tick();
    chk("redirect_data", d_instr, 32'h1111_2222);
    drive(0, 32'h300, 0, 0, 0, 32'h0, 0); tick();
    tick();

    // Flush during REQ (buffer holding an entry), then flush with data_ok in WAIT.
    drive(1, 32'h402, 0, 0, 0, 32'h0, 1); tick();
    drive(1, 32'h400, 0, 0, 0, 32'h0, 1); tick();
    chk("preflush_full", d_valid, 1);
    drive(1, 32'h400, 1, 0, 0, 32'h0, 1); tick();
    chk("req_held_after_flush", ibus_req, 1);
    chk("flush_clears_buf", d_valid, 0);
    drive(0, 32'h400, 0, 0, 0, 32'h0, 0); tick();
    chk("req_held_until_ok", ibus_req, 1);
    drive(0, 32'h400, 0, 1, 0, 32'h0, 0); tick();
    drive(0, 32'h400, 0, 0, 1, 32'h5555_5555, 0); tick();
    chk("req_flush_dropped", d_valid, 0);
    drive(1, 32'h500, 0, 0, 0, 32'h0, 0); tick();
    drive(0, 32'h500, 0, 1, 0, 32'h0, 0); tick();
    drive(0, 32'h500, 1, 0, 1, 32'h6666_6666, 0); tick();
    chk("same_cycle_dropped", d_valid, 0);
    drive(0, 32'h500, 0, 0, 0, 32'h0, 0); tick();
    chk("same_cycle_idle", ibus_req, 0);
    chk("same_cycle_empty", d_valid, 0);

    // Reset asserted while waiting for data; stale data after release is ignored.
    drive(1, 32'h600, 0, 0, 0, 32'h0, 0); tick();
    drive(0, 32'h600, 0, 1, 0, 32'h0, 0); tick();
    drive(0, 32'h600, 0, 0, 0, 32'h0, 0);
    resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_wait_addr", ibus_addr, 0);
    chk("rst_wait_dvalid", d_valid, 0);
    tick();
    resetn = 1'b1;
    drive(0, 32'h600, 0, 0, 1, 32'h7777_7777, 0); tick();
    chk("rst_no_stale", d_valid, 0);
    drive(0, 32'h600, 0, 0, 0, 32'h0, 0); tick();
    chk("rst_no_stale2", d_valid, 0);

    // Random traffic against the model.
    pc_reg = 32'h1000;
    for (int c = 0; c < 2000; c++) begin
      flush        = ($urandom % 20) == 0;
      f_valid      = ($urandom % 4) != 0;
      f_pc         = pc_reg;
      d_stall      = ($urandom % 3) == 0;
      ibus_addr_ok = m_req && (($urandom % 2) == 0);
      ibus_data_ok = m_resp && (($urandom % 3) != 0);
      ibus_data    = $urandom;
      @(negedge clk);
      check_model();
      fst = m_fstall;
      @(posedge clk);
      model_update();
      if (flush) begin
        pc_reg = $urandom;
        if (($urandom % 6) != 0) pc_reg[1:0] = 2'b00;
      end else if (!fst) begin
        pc_reg = pc_reg + 32'h4;
      end
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
